// File: rtl/audio_codec_feeder.sv
// audio_codec_feeder: attenuates/mutes mixed game audio samples, buffers them
// in a small FIFO and drains it into the DE1-SoC audio controller, writing the
// same sample to both channels. Flags dropped samples and drained-dry events.
module audio_codec_feeder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     sample_valid,
    input  logic [1:0]               volume_shift,
    input  logic                     mute,
    input  logic                     audio_out_allowed,
    input  logic                     clear_flags,
    output logic                     write_audio_out,
    output logic [WIDTH-1:0]         left_channel_audio_out,
    output logic [WIDTH-1:0]         right_channel_audio_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_LVL   = (AW+1)'(PRIME_LEVEL);
    localparam logic [AW:0] ONE_LEVEL   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR   = AW'(1);

    localparam logic ST_PRIME = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW:0]      level_q, level_d;
    logic             state_q, state_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] chan_q, chan_d;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;

    logic             fifoEmpty;
    logic             fifoFull;
    logic             doPop;
    logic             doPush;
    logic             overflowEvent;
    logic             underrunEvent;
    logic signed [WIDTH-1:0] shiftedSample;
    logic [WIDTH-1:0] pushData;

    assign fifoEmpty = (level_q == '0);
    assign fifoFull  = (level_q == FULL_LEVEL);

    // A pop frees a slot in the same cycle, so a push to a full FIFO that
    // coincides with a pop is still accepted.
    assign doPop         = (state_q == ST_RUN) && audio_out_allowed && !fifoEmpty;
    assign underrunEvent = (state_q == ST_RUN) && audio_out_allowed && fifoEmpty;
    assign doPush        = sample_valid && (!fifoFull || doPop);
    assign overflowEvent = sample_valid && fifoFull && !doPop;

    assign shiftedSample = $signed(sample_in) >>> volume_shift;
    assign pushData      = mute ? '0 : shiftedSample;

    // Next-state logic for pointers, occupancy, drain state, outputs and flags.
    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        level_d    = level_q;
        state_d    = state_q;
        write_d    = doPop;
        chan_d     = chan_q;
        overflow_d = overflow_q;
        underrun_d = underrun_q;

        if (doPop) begin
            rdPtr_d = rdPtr_q + ONE_PTR;
            chan_d  = mem_q[rdPtr_q];
        end
        if (doPush) begin
            wrPtr_d = wrPtr_q + ONE_PTR;
        end
        case ({doPush, doPop})
            2'b10:   level_d = level_q + ONE_LEVEL;
            2'b01:   level_d = level_q - ONE_LEVEL;
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_PRIME: if (level_q >= PRIME_LVL) state_d = ST_RUN;
            default:  if (underrunEvent)        state_d = ST_PRIME;
        endcase

        if (clear_flags) begin
            overflow_d = 1'b0;
            underrun_d = 1'b0;
        end
        if (overflowEvent) overflow_d = 1'b1;
        if (underrunEvent) underrun_d = 1'b1;
    end

    // Sample storage; contents need no reset because the pointers gate them.
    always_ff @(posedge CLOCK_50) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            level_q    <= '0;
            state_q    <= ST_PRIME;
            write_q    <= 1'b0;
            chan_q     <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            write_q    <= write_d;
            chan_q     <= chan_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign write_audio_out         = write_q;
    assign left_channel_audio_out  = chan_q;
    assign right_channel_audio_out = chan_q;
    assign fifo_level              = level_q;
    assign overflow                = overflow_q;
    assign underrun                = underrun_q;

endmodule

// File: tb/tb_audio_codec_feeder.sv
// Testbench for audio_codec_feeder: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_audio_codec_feeder;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 8;
    localparam int PRIME_LEVEL = 4;

    logic              CLOCK_50 = 1'b0;
    logic              resetn = 1'b0;
    logic [WIDTH-1:0]  sample_in = '0;
    logic              sample_valid = 1'b0;
    logic [1:0]        volume_shift = 2'd0;
    logic              mute = 1'b0;
    logic              audio_out_allowed = 1'b0;
    logic              clear_flags = 1'b0;
    logic              write_audio_out;
    logic [WIDTH-1:0]  left_channel_audio_out;
    logic [WIDTH-1:0]  right_channel_audio_out;
    logic [3:0]        fifo_level;
    logic              overflow;
    logic              underrun;

    audio_codec_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL)) dut (
        .CLOCK_50               (CLOCK_50),
        .resetn                 (resetn),
        .sample_in              (sample_in),
        .sample_valid           (sample_valid),
        .volume_shift           (volume_shift),
        .mute                   (mute),
        .audio_out_allowed      (audio_out_allowed),
        .clear_flags            (clear_flags),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .fifo_level             (fifo_level),
        .overflow               (overflow),
        .underrun               (underrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a queue of stored samples plus a "draining" bit.
    logic [WIDTH-1:0] mq [$];
    bit               mRun = 0;
    bit               mWrite = 0;
    logic [WIDTH-1:0] mOut = '0;
    bit               mOvf = 0;
    bit               mUnd = 0;

    // Values the DUT wrote to the codec, used by the literal checks.
    logic [WIDTH-1:0] wrLog [$];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int sizeBefore;
        bit pop;
        bit under;
        bit ovfEv;
        logic signed [WIDTH-1:0] sv;
        if (!resetn) begin
            mq.delete();
            mRun = 0; mWrite = 0; mOut = '0; mOvf = 0; mUnd = 0;
            return;
        end
        sizeBefore = mq.size();
        pop   = mRun && audio_out_allowed && sizeBefore > 0;
        under = mRun && audio_out_allowed && sizeBefore == 0;
        ovfEv = 0;
        mWrite = pop;
        if (pop) mOut = mq.pop_front();
        if (sample_valid) begin
            sv = sample_in;
            sv = sv >>> volume_shift;
            if (mute) sv = '0;
            if (sizeBefore < DEPTH || pop) mq.push_back(sv);
            else ovfEv = 1;
        end
        if (!mRun) mRun = (sizeBefore >= PRIME_LEVEL);
        else if (under) mRun = 0;
        mOvf = ovfEv || (mOvf && !clear_flags);
        mUnd = under || (mUnd && !clear_flags);
    endtask

    task automatic checkOutput();
        checkVal("write", 32'(write_audio_out), 32'(mWrite));
        checkVal("level", 32'(fifo_level), 32'(mq.size()));
        checkVal("overflow", 32'(overflow), 32'(mOvf));
        checkVal("underrun", 32'(underrun), 32'(mUnd));
        if (mWrite) begin
            checkVal("left", left_channel_audio_out, mOut);
            checkVal("right", right_channel_audio_out, mOut);
        end
        if (write_audio_out === 1'b1) wrLog.push_back(left_channel_audio_out);
    endtask

    // One clock cycle with the currently driven inputs; checks #1 after the edge.
    task automatic applyStimulus(input bit valid, input logic [31:0] data);
        sample_valid = valid;
        sample_in    = data;
        modelStep();
        @(posedge CLOCK_50);
        #1;
        checkOutput();
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    initial begin
        // Reset state
        doReset();
        checkVal("rst_level", 32'(fifo_level), 32'd0);
        checkVal("rst_write", 32'(write_audio_out), 32'd0);

        // Prime with four samples, then four single-cycle writes
        audio_out_allowed = 1'b1;
        wrLog.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h0400_0000);
        checkVal("no_write_while_priming", 32'(wrLog.size()), 32'd0);
        idle(6);
        checkVal("prime_write_count", 32'(wrLog.size()), 32'd4);
        for (int i = 0; i < wrLog.size(); i++) checkVal("prime_data", wrLog[i], 32'h0400_0000);
        checkVal("drained_level", 32'(fifo_level), 32'd0);

        // Attenuation and mute
        idle(2);
        clear_flags = 1'b1;
        idle(1);
        wrLog.delete();
        volume_shift = 2'd2;
        applyStimulus(1'b1, 32'h8000_0000);
        applyStimulus(1'b1, 32'h4000_0000);
        mute = 1'b1;
        applyStimulus(1'b1, 32'h7fff_ffff);
        applyStimulus(1'b1, 32'h1234_5678);
        mute = 1'b0;
        volume_shift = 2'd0;
        idle(6);
        checkVal("atten_count", 32'(wrLog.size()), 32'd4);
        if (wrLog.size() >= 3) begin
            checkVal("atten_neg", wrLog[0], 32'hE000_0000);
            checkVal("atten_pos", wrLog[1], 32'h1000_0000);
            checkVal("mute_zero", wrLog[2], 32'h0000_0000);
        end

        // Overflow with the codec blocked, then clear
        doReset();
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'hA000_0000 + 32'(i));
        checkVal("full_level", 32'(fifo_level), 32'd8);
        checkVal("overflow_set", 32'(overflow), 32'd1);
        clear_flags = 1'b1;
        idle(1);
        checkVal("overflow_clear", 32'(overflow), 32'd0);

        // Full FIFO: push coinciding with pop keeps level at DEPTH across wrap
        wrLog.delete();
        audio_out_allowed = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 32'hB000_0000 + 32'(i));
        checkVal("full_pop_level", 32'(fifo_level), 32'd8);
        checkVal("full_pop_no_ovf", 32'(overflow), 32'd0);
        checkVal("order_first", wrLog[0], 32'hA000_0000);
        checkVal("order_wrapped", wrLog[9], 32'hB000_0001);

        // Drain dry: underrun, back to priming
        idle(12);
        checkVal("underrun_set", 32'(underrun), 32'd1);
        clear_flags = 1'b1;
        idle(1);
        wrLog.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC000_0000 + 32'(i));
        idle(5);
        checkVal("reprime_no_write", 32'(wrLog.size()), 32'd0);
        applyStimulus(1'b1, 32'hC000_0003);
        idle(4);
        checkVal("reprime_resume", 32'(wrLog.size() != 0), 32'd1);
        idle(6);

        // Reset mid-drain with five samples still buffered
        doReset();
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'hD000_0000 + 32'(i));
        idle(2);
        audio_out_allowed = 1'b1;
        idle(3);
        checkVal("middrain_level", 32'(fifo_level), 32'd5);
        resetn = 1'b0;
        idle(1);
        checkVal("mid_rst_level", 32'(fifo_level), 32'd0);
        checkVal("mid_rst_write", 32'(write_audio_out), 32'd0);
        checkVal("mid_rst_ovf", 32'(overflow), 32'd0);
        resetn = 1'b1;
        wrLog.delete();
        idle(4);
        checkVal("mid_rst_prime", 32'(wrLog.size()), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            audio_out_allowed = ($urandom_range(0, 3) != 0);
            volume_shift      = 2'($urandom_range(0, 3));
            mute              = ($urandom_range(0, 9) == 0);
            clear_flags       = ($urandom_range(0, 19) == 0);
            resetn            = ($urandom_range(0, 299) != 0);
            applyStimulus($urandom_range(0, 2) == 0, $urandom);
        end
        resetn = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
